// File: rtl/multi_issue_select_if.sv
// rtl/multi_issue_select_if.sv - reservation-buffer/execution-unit bundle for the issue selector
interface multi_issue_select_if #(
  parameter int BUF_SIZE    = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int IDX_W       = $clog2(BUF_SIZE),
  parameter int CNT_W       = $clog2(ISSUE_WIDTH + 1)
);
  logic                                 flush;
  logic                                 is_tag_flooded;
  logic [BUF_SIZE-1:0]                  exec_rdy;
  logic [BUF_SIZE-1:0]                  addr_pending;
  logic [ISSUE_WIDTH-1:0]               out_valid;
  logic [ISSUE_WIDTH-1:0]               out_ready;
  logic [ISSUE_WIDTH*(IDX_W+1)-1:0]     out_tag;
  logic [ISSUE_WIDTH-1:0]               out_gen_addr;
  logic [BUF_SIZE-1:0]                  grant_mask;
  logic [CNT_W-1:0]                     slot_count;

  modport master (
    output flush, is_tag_flooded, exec_rdy, addr_pending, out_ready,
    input  out_valid, out_tag, out_gen_addr, grant_mask, slot_count
  );

  modport slave (
    input  flush, is_tag_flooded, exec_rdy, addr_pending, out_ready,
    output out_valid, out_tag, out_gen_addr, grant_mask, slot_count
  );
endinterface

// File: rtl/multi_issue_select.sv
// rtl/multi_issue_select.sv - oldest-first multi-slot issue selector with per-slot valid/ready
module multi_issue_select #(
  parameter int BUF_SIZE    = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int IDX_W       = $clog2(BUF_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_issue_select_if.slave  bus
);
  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

  if (ISSUE_WIDTH < 1 || ISSUE_WIDTH > 4 || ISSUE_WIDTH > BUF_SIZE) begin : g_bad_width
    $error("multi_issue_select: ISSUE_WIDTH must be 1..4 and not exceed BUF_SIZE");
  end

  logic [ISSUE_WIDTH-1:0]            valid_q, valid_d;
  logic [ISSUE_WIDTH-1:0][IDX_W:0]   tag_q, tag_d;
  logic [ISSUE_WIDTH-1:0]            gen_q, gen_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic [BUF_SIZE-1:0]               held;
  logic [BUF_SIZE-1:0]               avail;
  logic [BUF_SIZE-1:0]               grant;
  logic [ISSUE_WIDTH-1:0]            slot_open;
  logic [ISSUE_WIDTH-1:0]            fill;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] fill_idx;
  logic                              found;

  // Entries sitting in a stalled slot must not be picked again.
  always_comb begin
    held      = '0;
    slot_open = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      slot_open[s] = !valid_q[s] || bus.out_ready[s];
      if (valid_q[s] && !bus.out_ready[s]) begin
        held[tag_q[s][IDX_W-1:0]] = 1'b1;
      end
    end
  end

  // Each open slot in ascending order takes the lowest-index remaining candidate.
  always_comb begin
    avail    = bus.exec_rdy & ~held;
    grant    = '0;
    fill     = '0;
    fill_idx = '0;
    found    = 1'b0;
    if (!reset && !bus.flush) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        found = 1'b0;
        if (slot_open[s]) begin
          for (int e = 0; e < BUF_SIZE; e++) begin
            if (!found && avail[e]) begin
              found       = 1'b1;
              fill[s]     = 1'b1;
              fill_idx[s] = IDX_W'(e);
              avail[e]    = 1'b0;
              grant[e]    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    gen_d   = gen_q;
    cnt_d   = '0;
    if (bus.flush) begin
      valid_d = '0;
    end else begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (slot_open[s]) begin
          valid_d[s] = fill[s];
          if (fill[s]) begin
            tag_d[s] = {bus.is_tag_flooded, fill_idx[s]};
            gen_d[s] = bus.addr_pending[fill_idx[s]];
          end
        end
      end
    end
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[s]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      gen_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      gen_q   <= gen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_mask   = grant;
  assign bus.out_valid    = valid_q;
  assign bus.out_tag      = tag_q;
  assign bus.out_gen_addr = gen_q;
  assign bus.slot_count   = cnt_q;
endmodule

// File: doc/multi_issue_select.md
Name: multi_issue_select

Overview:
- Parametrised successor to the two-wide wakeup stage: chooses up to ISSUE_WIDTH executable reservation-buffer entries per cycle, oldest first.
- Holds the chosen entries in per-slot output registers with a valid/ready handshake toward the execution units.
- Returns a grant mask so the buffer can mark granted entries as in flight.
- Sits between the reservation buffer and the execution-unit dispatch. Payload is read from the buffer by index; this block carries no payload.

Parameters:
- BUF_SIZE, 8, number of reservation-buffer entries. Index 0 is the oldest entry, BUF_SIZE-1 the youngest.
- ISSUE_WIDTH, 2, number of issue slots (1..4).
- IDX_W, $clog2(BUF_SIZE), width of an entry index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  mispredict flush; empties all slots.
- is_tag_flooded  in  1  tag-epoch bit, prepended to the issued tag.
- exec_rdy  in  BUF_SIZE  per-entry "operands ready and not executed" (load ordering already applied).
- addr_pending  in  BUF_SIZE  per-entry "address not yet generated".
- out_valid  out  ISSUE_WIDTH  slot holds an issued entry.
- out_ready  in  ISSUE_WIDTH  execution unit accepts the slot this cycle.
- out_tag  out  ISSUE_WIDTH*(IDX_W+1)  per slot: {flood bit, entry index}.
- out_gen_addr  out  ISSUE_WIDTH  1 = EX_GEN_ADDR pass, 0 = EX_NORMAL.
- grant_mask  out  BUF_SIZE  combinational; entries captured into slots at the coming edge.
- slot_count  out  $clog2(ISSUE_WIDTH+1)  number of valid slots, registered.

Behaviour:
- Reset (asynchronous): out_valid=0, out_tag=0, out_gen_addr=0, slot_count=0. grant_mask=0 while reset is high.
- Slot open: slot s is open when !out_valid[s], or when out_valid[s] && out_ready[s] (a slot freed this cycle is refilled in the same cycle).
- Candidate: entry e is a candidate when exec_rdy[e]=1 and e is not held in any valid slot that is not being consumed this cycle.
- Held entries are masked defensively even though the buffer clears exec_rdy for granted entries from the next cycle.
- Selection: open slots are filled in ascending slot order. The lowest open slot gets the lowest-index candidate, the next open slot the next candidate, and so on.
  - Excess candidates wait; there is no rotation, so age order guarantees forward progress.
  - Fewer candidates than open slots: the remaining open slots go invalid, or stay invalid.
- grant_mask has one bit set per entry assigned this cycle, and popcount ≤ number of open slots.
- Capture at the clock edge into a filled slot:
  - out_tag = {is_tag_flooded, index}.
  - out_gen_addr = addr_pending[index].
  - out_valid = 1.
- A valid, non-ready slot keeps its tag and mode unchanged (stall). It never reorders and never takes a new entry.
- Latency: exec_rdy rising to out_valid is 1 cycle when a slot is open.
- flush: at the next edge all out_valid=0 and slot_count=0. grant_mask=0 during the flush cycle. out_ready is ignored that cycle.
- reset asserted mid-stall: slots clear immediately (asynchronous), and no grant is issued.
- slot_count is the popcount of next-state out_valid, registered together with the slots.
- Full: all slots valid and none ready → grant_mask=0 regardless of exec_rdy.
- Empty: exec_rdy=0 → grant_mask=0 and open slots fall invalid.
- ISSUE_WIDTH > BUF_SIZE is illegal (elaboration assertion).

Test Plan:
- Reset release, exec_rdy=8'b0010_0110, all out_ready=1 → grant_mask=8'b0000_0110. Next cycle: slot0 tag=1, slot1 tag=2, out_valid=2'b11, slot_count=2.
- Slot0 holds entry 1 with out_ready=2'b10 and exec_rdy=8'b0010_0101 (entry 1 cleared) → slot0 keeps tag 1, slot1 takes entry 0, grant_mask=8'b0000_0001.
- Both slots stalled for 5 cycles with exec_rdy=8'hFF → grant_mask=0 every cycle; tags unchanged.
- addr_pending[3]=1, exec_rdy=8'b0000_1000, is_tag_flooded=1 → slot0 tag=4'b1011, out_gen_addr[0]=1.
- flush asserted with both slots valid and exec_rdy=8'h0F → grant_mask=0, next cycle out_valid=0, slot_count=0. The cycle after that, entries 0 and 1 are granted.
- ISSUE_WIDTH=4, BUF_SIZE=16, exec_rdy=16'h8421 → slots 0..3 get tags 0, 5, 10, 15, slot_count=4.
- Async reset pulse mid-stall → out_valid=0 without waiting for a clk edge.
